// File: rtl/icache_responder_if.sv
// Instruction-side cache bus: datapath request/response and memory fill.
// The cache is the slave; the pipeline and memory model sit on master.
interface icache_responder_if;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;

   modport slave (
      input  imemREN,
      input  imemaddr,
      input  iwait,
      input  iload,
      output ihit,
      output imemload,
      output iREN,
      output iaddr
   );

   modport master (
      output imemREN,
      output imemaddr,
      output iwait,
      output iload,
      input  ihit,
      input  imemload,
      input  iREN,
      input  iaddr
   );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped one-word-per-frame instruction cache.
// Misses fetch a single word from memory and install it unconditionally.
module icache_responder #(
   parameter int SETS = 16
) (
   input  logic              CLK,
   input  logic              RST,
   icache_responder_if.slave bus,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   localparam int IDX  = $clog2(SETS);
   localparam int TAGW = 30 - IDX;

   typedef enum logic {
      IDLE,
      FETCH
   } state_e;

   state_e state_q, state_d;

   logic [29:0]     miss_addr_q, miss_addr_d;
   logic [SETS-1:0] valid_q, valid_d;
   logic [31:0]     hit_cnt_q, hit_cnt_d;
   logic [31:0]     miss_cnt_q, miss_cnt_d;

   logic [TAGW-1:0] tag_q  [SETS];
   logic [31:0]     data_q [SETS];

   logic [IDX-1:0]  req_idx;
   logic [TAGW-1:0] req_tag;
   logic [IDX-1:0]  fill_idx;
   logic [TAGW-1:0] fill_tag;
   logic            hit;
   logic            fill;
   logic            iren;
   logic [31:0]     iaddr;
   logic            unused_lsb;

   assign req_idx    = bus.imemaddr[IDX+1:2];
   assign req_tag    = bus.imemaddr[31:IDX+2];
   assign fill_idx   = miss_addr_q[IDX-1:0];
   assign fill_tag   = miss_addr_q[29:IDX];
   assign unused_lsb = ^bus.imemaddr[1:0];

   always_comb begin
      state_d     = state_q;
      miss_addr_d = miss_addr_q;
      valid_d     = valid_q;
      miss_cnt_d  = miss_cnt_q;
      hit         = 1'b0;
      fill        = 1'b0;
      iren        = 1'b0;
      iaddr       = 32'h0;
      unique case (state_q)
         IDLE: begin
            if (bus.imemREN) begin
               if (valid_q[req_idx] &&
                   tag_q[req_idx] == req_tag) begin
                  hit = 1'b1;
               end else begin
                  miss_addr_d = bus.imemaddr[31:2];
                  miss_cnt_d  = miss_cnt_q + 32'd1;
                  state_d     = FETCH;
               end
            end
         end
         FETCH: begin
            // the fill always finishes, even if imemaddr was redirected
            iren  = 1'b1;
            iaddr = {miss_addr_q, 2'b00};
            if (!bus.iwait) begin
               fill              = 1'b1;
               valid_d[fill_idx] = 1'b1;
               state_d           = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      hit_cnt_d = hit_cnt_q + {31'b0, hit};
   end

   assign bus.ihit     = hit;
   assign bus.imemload = hit ? data_q[req_idx] : 32'h0;
   assign bus.iREN     = iren;
   assign bus.iaddr    = iaddr;
   assign hit_count    = hit_cnt_q;
   assign miss_count   = miss_cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         miss_addr_q <= 30'h0;
         valid_q     <= '0;
         hit_cnt_q   <= 32'h0;
         miss_cnt_q  <= 32'h0;
      end else begin
         state_q     <= state_d;
         miss_addr_q <= miss_addr_d;
         valid_q     <= valid_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   // tag/data need no reset; valid alone gates their use
   always_ff @(posedge CLK) begin
      if (fill && !RST) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= bus.iload;
      end
   end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder with a queue-based scoreboard.
// A wait-state memory model answers fills; a monitor checks every edge.
module tb_icache_responder;

   logic        clk;
   logic        rst;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   icache_responder_if bus ();

   icache_responder #(.SETS(16)) dut (
      .CLK        (clk),
      .RST        (rst),
      .bus        (bus),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int mem_w  = 0;
   int wcnt   = 0;

   logic [31:0] exp_hit  [$];
   logic [31:0] exp_fill [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'h0000_0004: return 32'h2408_0001;
         32'h0000_0000: return 32'hAAAA_0000;
         32'h0000_0040: return 32'hBBBB_0040;
         32'h0000_0010: return 32'h1111_0010;
         32'h0000_0020: return 32'h2222_0020;
         32'h0000_0008: return 32'h8888_0008;
         default:       return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   // memory: W busy cycles, then one data cycle
   always @(posedge clk) begin
      #1;
      if (bus.iREN) begin
         if (wcnt < mem_w) begin
            bus.iwait = 1'b1;
            bus.iload = 32'h0;
            wcnt++;
         end else begin
            bus.iwait = 1'b0;
            bus.iload = mem(bus.iaddr);
            wcnt = 0;
         end
      end else begin
         bus.iwait = 1'b1;
         bus.iload = 32'h0;
         wcnt = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.ihit) begin
            if (exp_hit.size() == 0) begin
               n_chk++;
               $display("FAIL hit_extra: got ihit addr %h want none",
                        bus.imemaddr);
            end else begin
               check("hit_data", bus.imemload, exp_hit.pop_front());
            end
            check("hit_no_iren", {31'b0, bus.iREN}, 32'h0);
         end else begin
            check("load_zero", bus.imemload, 32'h0);
         end
         if (!bus.iREN) check("iaddr_idle", bus.iaddr, 32'h0);
         if (bus.iREN && !bus.iwait) begin
            if (exp_fill.size() == 0) begin
               n_chk++;
               $display("FAIL fill_extra: got iaddr %h want none",
                        bus.iaddr);
            end else begin
               check("fill_addr", bus.iaddr, exp_fill.pop_front());
            end
         end
      end
   end

   task automatic do_reset;
      rst = 1'b1;
      bus.imemREN = 1'b0;
      bus.imemaddr = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ihit", {31'b0, bus.ihit}, 32'h0);
      check("rst_load", bus.imemload, 32'h0);
      check("rst_iren", {31'b0, bus.iREN}, 32'h0);
      check("rst_iaddr", bus.iaddr, 32'h0);
      check("rst_hits", hit_count, 32'h0);
      check("rst_misses", miss_count, 32'h0);
      @(posedge clk);
      #1;
   endtask

   // one request held until ihit, then released
   task automatic req(input logic [31:0] a, input int w,
                      input logic [31:0] d, input bit miss);
      int cyc;
      int ren;
      bit got;
      mem_w = w;
      exp_hit.push_back(d);
      if (miss) exp_fill.push_back(a);
      bus.imemREN = 1'b1;
      bus.imemaddr = a;
      cyc = 0;
      ren = 0;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.ihit) got = 1;
         else begin
            cyc++;
            if (bus.iREN) ren++;
         end
      end
      check("req_done", {31'b0, got}, 32'h1);
      check("req_latency", cyc, miss ? w + 2 : 0);
      if (miss) check("req_iren_cycles", ren, w + 1);
      @(posedge clk);
      #1 bus.imemREN = 1'b0;
   endtask

   initial begin
      bit got;
      bit phase1;
      rst = 1'b1;
      bus.imemREN = 1'b0;
      bus.imemaddr = 32'h0;
      bus.iwait = 1'b1;
      bus.iload = 32'h0;
      do_reset();

      // cold miss
      req(32'h4, 2, 32'h2408_0001, 1);
      check("s1_miss", miss_count, 32'd1);
      check("s1_hit", hit_count, 32'd1);

      // warm hits
      repeat (3) exp_hit.push_back(32'h2408_0001);
      bus.imemREN = 1'b1;
      bus.imemaddr = 32'h4;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("s2_ihit", {31'b0, bus.ihit}, 32'h1);
         check("s2_iren", {31'b0, bus.iREN}, 32'h0);
         @(posedge clk);
         #1;
      end
      bus.imemREN = 1'b0;
      check("s2_hit", hit_count, 32'd4);
      check("s2_miss", miss_count, 32'd1);

      // conflict eviction at index 0
      do_reset();
      req(32'h00, 1, 32'hAAAA_0000, 1);
      req(32'h40, 0, 32'hBBBB_0040, 1);
      req(32'h00, 2, 32'hAAAA_0000, 1);
      check("s3_miss", miss_count, 32'd3);
      check("s3_hit", hit_count, 32'd3);

      // redirect during fill
      mem_w = 3;
      exp_fill.push_back(32'h10);
      exp_fill.push_back(32'h20);
      exp_hit.push_back(32'h2222_0020);
      bus.imemREN = 1'b1;
      bus.imemaddr = 32'h10;
      @(posedge clk);
      #1 bus.imemaddr = 32'h20;
      got = 0;
      phase1 = 1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.ihit) got = 1;
         else if (bus.iREN && phase1) begin
            check("s4_iaddr_hold", bus.iaddr, 32'h10);
            if (!bus.iwait) phase1 = 0;
         end
      end
      check("s4_done", {31'b0, got}, 32'h1);
      @(posedge clk);
      #1 bus.imemREN = 1'b0;
      req(32'h10, 3, 32'h1111_0010, 0);
      check("s4_miss", miss_count, 32'd5);
      check("s4_hit", hit_count, 32'd5);

      // reset while fetching
      mem_w = 3;
      bus.imemREN = 1'b1;
      bus.imemaddr = 32'h8;
      @(posedge clk);
      #1 rst = 1'b1;
      bus.imemREN = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("s5_iren", {31'b0, bus.iREN}, 32'h0);
      check("s5_miss0", miss_count, 32'd0);
      check("s5_hit0", hit_count, 32'd0);
      @(posedge clk);
      #1;
      req(32'h8, 3, 32'h8888_0008, 1);
      check("s5_miss1", miss_count, 32'd1);
      req(32'h10, 0, 32'h1111_0010, 1);
      check("s5_miss2", miss_count, 32'd2);

      // idle
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("s6_ihit", {31'b0, bus.ihit}, 32'h0);
         check("s6_iren", {31'b0, bus.iREN}, 32'h0);
      end
      check("s6_hit", hit_count, 32'd2);
      check("s6_miss", miss_count, 32'd2);

      check("hitq_empty", exp_hit.size(), 32'd0);
      check("fillq_empty", exp_fill.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
